// File: rtl/caesar_sram_pkg.sv
// Shared types and address-decode helpers for the Caesar banked SRAM wrapper.
package caesar_sram_pkg;

    typedef enum logic [1:0] {
        ST_ACTIVE    = 2'd0,
        ST_RETENTIVE = 2'd1,
        ST_WAKEUP    = 2'd2
    } sram_state_e;

    // bank_bits == 0 means a single bank: everything maps to bank 0.
    function automatic int unsigned bank_of(input int unsigned addr, input int unsigned addr_width,
                                            input int unsigned bank_bits, input bit interleaved);
        if (bank_bits == 32'd0) return 32'd0;
        if (interleaved) return addr & ((32'd1 << bank_bits) - 32'd1);
        return (addr >> (addr_width - bank_bits)) & ((32'd1 << bank_bits) - 32'd1);
    endfunction

    function automatic int unsigned row_of(input int unsigned addr, input int unsigned addr_width,
                                           input int unsigned bank_bits, input bit interleaved);
        if (bank_bits == 32'd0) return addr;
        if (interleaved) return addr >> bank_bits;
        return addr & ((32'd1 << (addr_width - bank_bits)) - 32'd1);
    endfunction

endpackage

// File: rtl/caesar_sram_bank.sv
// Single-port byte-writable inferred RAM bank with a registered read port.
module caesar_sram_bank #(
    parameter int ROWS       = 256,
    parameter int DATA_WIDTH = 32,
    localparam int RowBits   = (ROWS > 1) ? $clog2(ROWS) : 1,
    localparam int BeWidth   = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  en,
    input  logic                  we,
    input  logic [RowBits-1:0]    row,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [BeWidth-1:0]    be,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [ROWS];
    logic [DATA_WIDTH-1:0] rdata_reg;

    // Contents and read register are deliberately unreset so this maps onto block RAM.
    always_ff @(posedge clk) begin
        if (en && we) begin
            for (int k = 0; k < BeWidth; k++) begin
                if (be[k]) mem[row][k*8 +: 8] <= wdata[k*8 +: 8];
            end
        end
        if (en && !we) rdata_reg <= mem[row];
    end

    assign rdata = rdata_reg;

endmodule

// File: rtl/caesar_sram_banked_wrapper.sv
// Multi-bank SRAM wrapper: req/gnt/rvalid handshake, optional output register,
// and a retention/wake-up sequencer that gates grants.
module caesar_sram_banked_wrapper
    import caesar_sram_pkg::*;
#(
    parameter int NUM_WORDS     = 1024,
    parameter int DATA_WIDTH    = 32,
    parameter int NUM_BANKS     = 4,
    parameter int INTERLEAVED   = 1,
    parameter int OUT_REG       = 0,
    parameter int WAKEUP_CYCLES = 4,
    localparam int AddrWidth    = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1,
    localparam int BankSelWidth = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1,
    localparam int BeWidth      = DATA_WIDTH / 8
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  req_i,
    output logic                  gnt_o,
    input  logic                  we_i,
    input  logic [AddrWidth-1:0]  addr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic [BeWidth-1:0]    be_i,
    input  logic                  set_retentive_ni,
    output logic                  ready_o,
    output logic                  rvalid_o,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    localparam int BankBits = $clog2(NUM_BANKS);
    localparam int RowWidth = AddrWidth - BankBits;
    localparam int RowBits  = (RowWidth > 0) ? RowWidth : 1;
    localparam int Rows     = NUM_WORDS / NUM_BANKS;
    localparam int CntWidth = (WAKEUP_CYCLES > 0) ? $clog2(WAKEUP_CYCLES + 1) : 1;

    sram_state_e         state_reg, state_next;
    logic [CntWidth-1:0] cnt_reg, cnt_next;

    assign ready_o = (state_reg == ST_ACTIVE);
    assign gnt_o   = req_i & ready_o & set_retentive_ni;

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            ST_ACTIVE: begin
                if (!set_retentive_ni) state_next = ST_RETENTIVE;
            end
            ST_RETENTIVE: begin
                if (set_retentive_ni) begin
                    if (WAKEUP_CYCLES == 0) begin
                        state_next = ST_ACTIVE;
                    end else begin
                        state_next = ST_WAKEUP;
                        cnt_next   = CntWidth'(WAKEUP_CYCLES - 1);
                    end
                end
            end
            ST_WAKEUP: begin
                if (!set_retentive_ni) begin
                    state_next = ST_RETENTIVE;
                    cnt_next   = '0;
                end else if (cnt_reg == '0) begin
                    state_next = ST_ACTIVE;
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                end
            end
            default: begin
                state_next = ST_ACTIVE;
                cnt_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg <= ST_ACTIVE;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    logic [BankSelWidth-1:0] bank_sel;
    logic [RowBits-1:0]      row_sel;

    assign bank_sel = BankSelWidth'(bank_of(32'(addr_i), AddrWidth, BankBits, INTERLEAVED != 0));
    assign row_sel  = RowBits'(row_of(32'(addr_i), AddrWidth, BankBits, INTERLEAVED != 0));

    logic [DATA_WIDTH-1:0] bank_rdata [NUM_BANKS];

    for (genvar gi = 0; gi < NUM_BANKS; gi++) begin : g_bank
        caesar_sram_bank #(
            .ROWS       (Rows),
            .DATA_WIDTH (DATA_WIDTH)
        ) u_bank (
            .clk   (clk_i),
            .en    (gnt_o && (bank_sel == BankSelWidth'(gi))),
            .we    (we_i),
            .row   (row_sel),
            .wdata (wdata_i),
            .be    (be_i),
            .rdata (bank_rdata[gi])
        );
    end

    // First response stage: aligned with the bank read registers.
    logic                    s1_valid_reg;
    logic                    s1_read_reg;
    logic [BankSelWidth-1:0] s1_bank_reg;
    logic [DATA_WIDTH-1:0]   resp_data;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_valid_reg <= 1'b0;
            s1_read_reg  <= 1'b0;
            s1_bank_reg  <= '0;
        end else begin
            s1_valid_reg <= gnt_o;
            if (gnt_o) begin
                s1_read_reg <= ~we_i;
                if (!we_i) s1_bank_reg <= bank_sel;
            end
        end
    end

    assign resp_data = s1_read_reg ? bank_rdata[s1_bank_reg] : '0;

    if (OUT_REG != 0) begin : g_out_reg
        logic                  valid_reg;
        logic [DATA_WIDTH-1:0] data_reg;

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                valid_reg <= 1'b0;
                data_reg  <= '0;
            end else begin
                valid_reg <= s1_valid_reg;
                if (s1_valid_reg) data_reg <= resp_data;
            end
        end

        assign rvalid_o = valid_reg;
        assign rdata_o  = data_reg;
    end else begin : g_out_comb
        // Bank outputs are unreset, so a hold register supplies the idle/reset value.
        logic [DATA_WIDTH-1:0] hold_reg;

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                hold_reg <= '0;
            end else if (s1_valid_reg) begin
                hold_reg <= resp_data;
            end
        end

        assign rvalid_o = s1_valid_reg;
        assign rdata_o  = s1_valid_reg ? resp_data : hold_reg;
    end

endmodule

// File: doc/caesar_sram_banked_wrapper.md
# caesar_sram_banked_wrapper

Parametrised, multi-bank, behavioural SRAM wrapper for the Caesar near-memory subsystem on Xilinx FPGAs. It replaces the fixed 32-bit single-bank vendor macro with inferred block RAM banks of configurable width, depth and bank count. It adds a req/gnt/rvalid handshake, an optional output register stage and a retention/wake-up sequencer that emulates the ASIC power-management behaviour on FPGA.

## Interface
- NUM_WORDS, 1024: total words across all banks; must be a multiple of NUM_BANKS.
- DATA_WIDTH, 32: word width; must be a multiple of 8.
- NUM_BANKS, 4: number of banks; power of two, ≥1.
- INTERLEAVED, 1: 1 = bank selected by address LSBs; 0 = bank selected by address MSBs.
- OUT_REG, 0: 1 = extra output register stage (+1 cycle read latency).
- WAKEUP_CYCLES, 4: cycles from retention exit to first grant; 0 allowed.
- Localparams (not overridable): AddrWidth = max(1, clog2(NUM_WORDS)); BankSelWidth = max(1, clog2(NUM_BANKS)); RowWidth = AddrWidth − clog2(NUM_BANKS); BeWidth = DATA_WIDTH/8.
- clk_i  in  1  clock.
- rst_ni  in  1  reset; asynchronous, active-low (one clock, async active-low reset).
- req_i  in  1  access request.
- gnt_o  out  1  request accepted this cycle.
- we_i  in  1  1 = write, 0 = read.
- addr_i  in  AddrWidth  word address.
- wdata_i  in  DATA_WIDTH  write data.
- be_i  in  BeWidth  byte enables; writes only.
- set_retentive_ni  in  1  0 = enter or hold retention.
- ready_o  out  1  FSM in ACTIVE.
- rvalid_o  out  1  response valid; one response per grant, reads and writes.
- rdata_o  out  DATA_WIDTH  read data; 0 on write responses.

## Operation
- gnt_o = req_i & ready_o & set_retentive_ni. This is combinational, with no dependency on we_i or the address.
- Bank mapping when INTERLEAVED=1:
  - bank = addr_i[BankSelWidth-1:0]
  - row = addr_i[AddrWidth-1:BankSelWidth]
- Bank mapping when INTERLEAVED=0:
  - bank = MSBs
  - row = LSBs
- When NUM_BANKS=1, the bank index is 0 and the row equals addr_i.
- Granted write: each byte lane k with be_i[k]=1 is written; other lanes are unchanged. be_i=0 is a legal no-op write that still gets a response.
- Granted read: the addressed bank is read and the selected bank index is registered to steer the output mux.
- Read-during-write to the same address in the same cycle cannot occur, because there is a single port and one access per cycle.
- Memory contents are not affected by rst_ni and are preserved across retention. FPGA power-up contents are all zero.
- FSM states:
  - ACTIVE (reset state): goes to RETENTIVE when set_retentive_ni=0.
  - RETENTIVE: stays while set_retentive_ni=0. When set_retentive_ni=1, goes to WAKEUP, or directly to ACTIVE if WAKEUP_CYCLES=0.
  - WAKEUP: counter loads WAKEUP_CYCLES−1 on entry and decrements each cycle; goes to ACTIVE on the cycle the counter reads 0. If set_retentive_ni=0 in WAKEUP, goes to RETENTIVE and the counter is discarded.
- Responses already in flight when retention is entered complete normally; the pipeline never stalls.

## Timing
- Reset values: gnt_o=0 (req_i low implied), ready_o=1, rvalid_o=0, rdata_o=0, FSM=ACTIVE, counter=0. All internal pipeline valids are 0.
- Latency from a grant in cycle T:
  - OUT_REG=0: rvalid_o high in T+1.
  - OUT_REG=1: rvalid_o high in T+2.
- Throughput is one access per cycle. Back-to-back grants give back-to-back rvalid_o, in order.
- rdata_o holds its last value when rvalid_o=0. It is meaningful only when rvalid_o=1.
- Retention entry: set_retentive_ni falls in cycle T, so gnt_o=0 in T (combinational) and ready_o=0 from T+1.
- Wake-up: set_retentive_ni rises in cycle R, so ready_o rises in R+1+WAKEUP_CYCLES.
- Asynchronous reset mid-operation drops all in-flight responses; no rvalid_o is issued for them.

## Structure
- caesar_sram_pkg holds:
  - the state enum (ACTIVE, RETENTIVE, WAKEUP)
  - helper functions for bank and row extraction
- Sub-module caesar_sram_bank:
  - a single-port byte-write inferred RAM
  - parameters: ROWS and DATA_WIDTH
  - one registered read port
  - instantiated NUM_BANKS times in a generate loop
- The top level contains the FSM, the wake-up counter, the bank-select register, the output mux and the optional OUT_REG stage.

## Test plan
- NUM_BANKS=4, INTERLEAVED=1, OUT_REG=0:
  - stimulus: write 0xA5A5A5A5 to addrs 0..7, then read 0..7 back-to-back
  - required response: 8 consecutive rvalid_o pulses starting one cycle after the first read grant, data 0xA5A5A5A5; addrs 0–3 hit banks 0–3.
- Byte enables:
  - stimulus: write 0xFFFFFFFF to addr 5, then write 0x11223344 with be_i=4'b0101, then read addr 5
  - required response: 0xFF22FF44.
- OUT_REG=1, INTERLEAVED=0, NUM_WORDS=1024:
  - stimulus: read addr 0x3FF after writing 0xDEADBEEF to it
  - required response: rvalid_o and data 2 cycles after the grant, bank 3 used.
- Retention, WAKEUP_CYCLES=4:
  - stimulus: drop set_retentive_ni for 10 cycles with req_i=1 held, then raise it
  - required response: gnt_o=0 throughout retention; ready_o high 5 cycles after the rise; the previously written data is intact.
- Wake-up abort:
  - stimulus: lower set_retentive_ni again 2 cycles into WAKEUP
  - required response: FSM returns to RETENTIVE and ready_o stays 0.
- Reset with 2 reads in flight (OUT_REG=1):
  - stimulus: assert rst_ni low while the reads are in flight
  - required response: no rvalid_o for those reads; rdata_o=0 and ready_o=1 after reset release.
